// File: rtl/gpio_arb_if.sv
// Two-master GPIO register-port bundle: master request/response pairs, the shared
// GPIO register port and the grant owner, with arbiter-side and environment-side views.
interface gpio_arb_if #(
   parameter int DW = 32,
   parameter int AW = 2
);
   logic          m0_req;
   logic          m0_we;
   logic [AW-1:0] m0_a;
   logic [DW-1:0] m0_wd;
   logic          m0_ack;
   logic [DW-1:0] m0_rd;

   logic          m1_req;
   logic          m1_we;
   logic [AW-1:0] m1_a;
   logic [DW-1:0] m1_wd;
   logic          m1_ack;
   logic [DW-1:0] m1_rd;

   logic [AW-1:0] gp_a;
   logic          gp_we;
   logic [DW-1:0] gp_wd;
   logic [DW-1:0] gp_rd;

   logic          owner;

   modport slave (
      input  m0_req, m0_we, m0_a, m0_wd,
      output m0_ack, m0_rd,
      input  m1_req, m1_we, m1_a, m1_wd,
      output m1_ack, m1_rd,
      output gp_a, gp_we, gp_wd,
      input  gp_rd,
      output owner
   );

   modport master (
      output m0_req, m0_we, m0_a, m0_wd,
      input  m0_ack, m0_rd,
      output m1_req, m1_we, m1_a, m1_wd,
      input  m1_ack, m1_rd,
      input  gp_a, gp_we, gp_wd,
      output gp_rd,
      input  owner
   );
endinterface

// File: rtl/gpio_arb.sv
// Round-robin arbiter giving two masters single-beat access to one GPIO register port.
// Each access takes IDLE -> ACCESS -> RESP, and every output comes straight from a flop.
module gpio_arb #(
   parameter int DW = 32,
   parameter int AW = 2
) (
   input logic       clk,
   input logic       rst,
   gpio_arb_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        state_r, state_nxt;
   logic          owner_r, owner_nxt;
   logic          we_r, we_nxt;
   logic [AW-1:0] gp_a_r, gp_a_nxt;
   logic [DW-1:0] gp_wd_r, gp_wd_nxt;
   logic          gp_we_r, gp_we_nxt;
   logic          m0_ack_r, m0_ack_nxt;
   logic          m1_ack_r, m1_ack_nxt;
   logic [DW-1:0] m0_rd_r, m0_rd_nxt;
   logic [DW-1:0] m1_rd_r, m1_rd_nxt;
   logic          win_s;

   // Round-robin pick: on contention the master that was not last granted wins.
   always_comb begin
      win_s = 1'b0;
      if (bus.m0_req && bus.m1_req) begin
         win_s = ~owner_r;
      end else if (bus.m1_req) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Next-state and next-output logic; the GPIO port registers double as the request latch.
   always_comb begin
      state_nxt  = state_r;
      owner_nxt  = owner_r;
      we_nxt     = we_r;
      gp_a_nxt   = gp_a_r;
      gp_wd_nxt  = gp_wd_r;
      gp_we_nxt  = 1'b0;
      m0_ack_nxt = 1'b0;
      m1_ack_nxt = 1'b0;
      m0_rd_nxt  = m0_rd_r;
      m1_rd_nxt  = m1_rd_r;
      case (state_r)
         IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               owner_nxt = win_s;
               state_nxt = ACCESS;
               if (win_s) begin
                  we_nxt    = bus.m1_we;
                  gp_a_nxt  = bus.m1_a;
                  gp_wd_nxt = bus.m1_wd;
                  gp_we_nxt = bus.m1_we;
               end else begin
                  we_nxt    = bus.m0_we;
                  gp_a_nxt  = bus.m0_a;
                  gp_wd_nxt = bus.m0_wd;
                  gp_we_nxt = bus.m0_we;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         ACCESS: begin
            state_nxt = RESP;
            if (owner_r) begin
               m1_ack_nxt = 1'b1;
               if (!we_r) begin
                  m1_rd_nxt = bus.gp_rd;
               end else begin
                  m1_rd_nxt = m1_rd_r;
               end
            end else begin
               m0_ack_nxt = 1'b1;
               if (!we_r) begin
                  m0_rd_nxt = bus.gp_rd;
               end else begin
                  m0_rd_nxt = m0_rd_r;
               end
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers; owner resets to 1 so m0 wins the first contention.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= IDLE;
         owner_r  <= 1'b1;
         we_r     <= 1'b0;
         gp_a_r   <= {AW{1'b0}};
         gp_wd_r  <= {DW{1'b0}};
         gp_we_r  <= 1'b0;
         m0_ack_r <= 1'b0;
         m1_ack_r <= 1'b0;
         m0_rd_r  <= {DW{1'b0}};
         m1_rd_r  <= {DW{1'b0}};
      end else begin
         state_r  <= state_nxt;
         owner_r  <= owner_nxt;
         we_r     <= we_nxt;
         gp_a_r   <= gp_a_nxt;
         gp_wd_r  <= gp_wd_nxt;
         gp_we_r  <= gp_we_nxt;
         m0_ack_r <= m0_ack_nxt;
         m1_ack_r <= m1_ack_nxt;
         m0_rd_r  <= m0_rd_nxt;
         m1_rd_r  <= m1_rd_nxt;
      end
   end

   assign bus.gp_a   = gp_a_r;
   assign bus.gp_we  = gp_we_r;
   assign bus.gp_wd  = gp_wd_r;
   assign bus.m0_ack = m0_ack_r;
   assign bus.m1_ack = m1_ack_r;
   assign bus.m0_rd  = m0_rd_r;
   assign bus.m1_rd  = m1_rd_r;
   assign bus.owner  = owner_r;
endmodule

// File: tb/tb_gpio_arb.sv
// Scoreboard bench for gpio_arb: directed transactions push expected acks and GPIO
// writes into queues, and a negedge monitor pops and compares them as the DUT emits them.
module tb_gpio_arb;
   localparam int DW = 32;
   localparam int AW = 2;

   typedef struct {
      int            m;
      logic [DW-1:0] rd;
      int            cyc;
   } ack_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      int            cyc;
   } gpw_t;

   logic clk = 1'b0;
   logic rst;
   logic mem_load;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   n;

   ack_t ack_q[$];
   gpw_t gp_q[$];
   logic [DW-1:0] gp_mem [4];

   always #5 clk = ~clk;

   gpio_arb_if #(.DW(DW), .AW(AW)) bus ();

   gpio_arb #(.DW(DW), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // GPIO register file seen by the arbiter: combinational read, write on gp_we.
   always @(posedge clk) begin
      if (mem_load) begin
         gp_mem[0] <= 32'h1111_0000;
         gp_mem[1] <= 32'hA5A5_A5A5;
         gp_mem[2] <= 32'h1234_5678;
         gp_mem[3] <= 32'h0F0F_0F0F;
      end else if (bus.gp_we) begin
         gp_mem[bus.gp_a] <= bus.gp_wd;
      end
   end
   assign bus.gp_rd = gp_mem[bus.gp_a];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic set_m(input int m, input logic req, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
      if (m == 1) begin
         bus.m1_req = req; bus.m1_we = we; bus.m1_a = a; bus.m1_wd = wd;
      end else begin
         bus.m0_req = req; bus.m0_we = we; bus.m0_a = a; bus.m0_wd = wd;
      end
   endtask

   // Holds req for ntx transactions, dropping it just after the last ack cycle ends.
   task automatic master(input int m, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int ntx);
      logic got;
      set_m(m, 1'b1, we, a, wd);
      for (int k = 0; k < ntx; k++) begin
         got = 1'b0;
         for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = (m == 1) ? bus.m1_ack : bus.m0_ack;
         end
         check($sformatf("ack_timeout_m%0d", m), 32'(got), 32'd1);
         @(posedge clk);
         #1;
      end
      set_m(m, 1'b0, we, a, wd);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_owner"},  32'(bus.owner),  32'd1);
      check({tag, "_m0_ack"}, 32'(bus.m0_ack), 32'd0);
      check({tag, "_m1_ack"}, 32'(bus.m1_ack), 32'd0);
      check({tag, "_gp_we"},  32'(bus.gp_we),  32'd0);
      check({tag, "_gp_a"},   32'(bus.gp_a),   32'd0);
      check({tag, "_gp_wd"},  bus.gp_wd,       32'h0);
      check({tag, "_m0_rd"},  bus.m0_rd,       32'h0);
      check({tag, "_m1_rd"},  bus.m1_rd,       32'h0);
   endtask

   // Monitor: every ack and every gp_we cycle must match the head of its queue.
   always @(negedge clk) begin
      ack_t e;
      gpw_t g;
      int   m_act;
      if (rst && (bus.m0_ack || bus.m1_ack)) begin
         check("ack_exclusive", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
         check("ack_expected", 32'(ack_q.size() != 0), 32'd1);
         if (ack_q.size() != 0) begin
            e = ack_q.pop_front();
            m_act = bus.m1_ack ? 1 : 0;
            check("ack_master", 32'(m_act), 32'(e.m));
            check("ack_cycle", 32'(cyc), 32'(e.cyc));
            check("ack_rd", (m_act == 1) ? bus.m1_rd : bus.m0_rd, e.rd);
         end
      end
      if (bus.gp_we) begin
         check("gp_we_expected", 32'(gp_q.size() != 0), 32'd1);
         if (gp_q.size() != 0) begin
            g = gp_q.pop_front();
            check("gp_a", 32'(bus.gp_a), 32'(g.a));
            check("gp_wd", bus.gp_wd, g.wd);
            check("gp_we_cycle", 32'(cyc), 32'(g.cyc));
         end
      end
   end

   initial begin
      rst = 1'b0;
      mem_load = 1'b1;
      set_m(0, 1'b0, 1'b0, 2'd0, 32'h0);
      set_m(1, 1'b0, 1'b0, 2'd0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_checks("por");
      mem_load = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single write from m0
      @(posedge clk);
      #1;
      n = cyc;
      ack_q.push_back('{0, 32'h0, n + 2});
      gp_q.push_back('{2'd0, 32'hDEAD_BEEF, n + 1});
      master(0, 1'b1, 2'd0, 32'hDEAD_BEEF, 1);

      // Single read from m1
      n = cyc;
      ack_q.push_back('{1, 32'h1234_5678, n + 2});
      master(1, 1'b0, 2'd2, 32'h0, 1);

      // Reset, then sustained contention alternates m0, m1, m0, m1
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_checks("rst2");
      @(posedge clk);
      #1;
      rst = 1'b1;
      n = cyc;
      ack_q.push_back('{0, 32'hDEAD_BEEF, n + 2});
      ack_q.push_back('{1, 32'h0, n + 5});
      ack_q.push_back('{0, 32'hDEAD_BEEF, n + 8});
      ack_q.push_back('{1, 32'h0, n + 11});
      gp_q.push_back('{2'd3, 32'hCAFE_F00D, n + 4});
      gp_q.push_back('{2'd3, 32'hCAFE_F00D, n + 10});
      fork
         master(0, 1'b0, 2'd0, 32'h0, 2);
         master(1, 1'b1, 2'd3, 32'hCAFE_F00D, 2);
      join

      // Back-to-back writes from m0 holding req across its ack
      n = cyc;
      ack_q.push_back('{0, 32'hDEAD_BEEF, n + 2});
      ack_q.push_back('{0, 32'hDEAD_BEEF, n + 5});
      gp_q.push_back('{2'd1, 32'h55AA_55AA, n + 1});
      gp_q.push_back('{2'd1, 32'h55AA_55AA, n + 4});
      master(0, 1'b1, 2'd1, 32'h55AA_55AA, 2);

      // Withdrawal: m0 read drops req and scrambles fields after the grant
      n = cyc;
      ack_q.push_back('{0, 32'h55AA_55AA, n + 2});
      set_m(0, 1'b1, 1'b0, 2'd1, 32'h0);
      @(posedge clk);
      #1;
      set_m(0, 1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF);
      begin
         logic got;
         got = 1'b0;
         for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            got = bus.m0_ack;
         end
         check("withdraw_ack_timeout", 32'(got), 32'd1);
      end
      @(posedge clk);
      #1;

      // Reset during ACCESS of an m1 write aborts it without an ack
      n = cyc;
      gp_q.push_back('{2'd2, 32'h7777_7777, n + 1});
      set_m(1, 1'b1, 1'b1, 2'd2, 32'h7777_7777);
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_m(1, 1'b0, 1'b0, 2'd0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      reset_checks("midop");
      @(posedge clk);
      #1;
      rst = 1'b1;

      // After that reset m0 again wins the first contention
      n = cyc;
      ack_q.push_back('{0, 32'h7777_7777, n + 2});
      ack_q.push_back('{1, 32'hDEAD_BEEF, n + 5});
      fork
         master(0, 1'b0, 2'd2, 32'h0, 1);
         master(1, 1'b0, 2'd0, 32'h0, 1);
      join

      repeat (4) @(posedge clk);
      #1;
      check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
      check("gp_queue_drained", 32'(gp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
